gpu_reg_master: RTL and testbench

//  Avalon-MM initiator that drives the GPU register file's 8-bit QSYS slave port from the other end.

---
 rtl/gpu_reg_pkg.sv | 34 +++
 rtl/gpu_reg_master_if.sv | 37 +++
 rtl/gpu_reg_cmd_fifo.sv | 49 ++++
 rtl/gpu_reg_master.sv | 148 ++++++++++++++
 tb/tb_gpu_reg_master.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_reg_pkg.sv
// Shared types and constants for the GPU register-file Avalon initiator.
// Holds the register map, FSM states and the queued command format.
package gpu_reg_pkg;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 11;

   localparam logic [ADDR_W-1:0] REG_00 = 8'h00;
   localparam logic [ADDR_W-1:0] REG_01 = 8'h01;
   localparam logic [ADDR_W-1:0] REG_02 = 8'h02;
   localparam logic [ADDR_W-1:0] REG_03 = 8'h03;
   localparam logic [ADDR_W-1:0] REG_04 = 8'h04;
   localparam logic [ADDR_W-1:0] REG_05 = 8'h05;
   localparam logic [ADDR_W-1:0] REG_06 = 8'h06;
   localparam logic [ADDR_W-1:0] REG_07 = 8'h07;
   localparam logic [ADDR_W-1:0] REG_08 = 8'h08;
   localparam logic [ADDR_W-1:0] REG_09 = 8'h09;
   localparam logic [ADDR_W-1:0] REG_0A = 8'h0A;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD,
      RESP
   } state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/gpu_reg_master_if.sv
// Command, response and Avalon-MM signals of the register master.
// master = the initiator block, slave = sequencer plus register file.
interface gpu_reg_master_if;
   import gpu_reg_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_write;
   logic              avm_read;
   logic [DATA_W-1:0] avm_writedata;
   logic              avm_waitrequest;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_readdatavalid;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid,
      output cmd_ready, avm_address, avm_write, avm_read,
      output avm_writedata, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  cmd_ready, avm_address, avm_write, avm_read,
      input  avm_writedata, rsp_valid, rsp_rdata, rsp_err, busy
   );

endinterface

// File: rtl/gpu_reg_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit
// so that full and empty are told apart without a counter.
module gpu_reg_cmd_fifo
   import gpu_reg_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_push,
   input  logic i_pop,
   input  cmd_t i_data,
   output cmd_t o_data,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);

   cmd_t         r_mem [DEPTH];
   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic         w_push;
   logic         w_pop;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_data  = r_mem[r_rptr[AW-1:0]];

   // advance read/write pointers on accepted push/pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // storage array, no reset needed
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/gpu_reg_master.sv
// Avalon-MM initiator for the GPU register file: queues commands,
// issues one transfer at a time and returns one response each.
module gpu_reg_master
   import gpu_reg_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int RD_TIMEOUT = 255
) (
   input  logic      clk,
   input  logic      reset,
   gpu_reg_master_if.master bus
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(NUM_REGS - 1);

   state_t            r_state;
   state_t            w_next;
   cmd_t              w_head;
   cmd_t              w_cmd_in;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_bad;
   logic              w_timeout;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              r_avm_write;
   logic              r_avm_read;
   logic [ADDR_W-1:0] r_avm_addr;
   logic [DATA_W-1:0] r_avm_wdata;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;

   assign w_cmd_in  = '{write: bus.cmd_write,
                        addr:  bus.cmd_addr,
                        wdata: bus.cmd_wdata};
   assign w_push    = bus.cmd_valid & ~w_full;
   assign w_bad     = (w_head.addr > MAX_ADDR);
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_timeout = (w_cnt_inc == CNT_W'(RD_TIMEOUT));

   gpu_reg_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_cmd_in),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // next state and FIFO pop
   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = w_bad ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.avm_waitrequest)
               w_next = r_avm_read ? WAIT_RD : RESP;
         end
         WAIT_RD: begin
            if (bus.avm_readdatavalid || w_timeout)
               w_next = RESP;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Avalon outputs, timeout counter and response registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_avm_write <= 1'b0;
         r_avm_read  <= 1'b0;
         r_avm_addr  <= '0;
         r_avm_wdata <= '0;
         r_cnt       <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_rsp_rdata <= '0;
               r_rsp_err   <= 1'b0;
               if (w_pop && w_bad) begin
                  r_rsp_err <= 1'b1;
               end else if (w_pop) begin
                  r_avm_write <= w_head.write;
                  r_avm_read  <= ~w_head.write;
                  r_avm_addr  <= w_head.addr;
                  r_avm_wdata <= w_head.write ? w_head.wdata : '0;
               end
            end
            ISSUE: begin
               if (!bus.avm_waitrequest) begin
                  r_avm_write <= 1'b0;
                  r_avm_read  <= 1'b0;
                  r_avm_addr  <= '0;
                  r_avm_wdata <= '0;
                  r_cnt       <= '0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= '0;
               end
            end
            WAIT_RD: begin
               r_cnt <= w_cnt_inc;
               if (bus.avm_readdatavalid) begin
                  r_rsp_rdata <= bus.avm_readdata;
                  r_rsp_err   <= 1'b0;
               end else if (w_timeout) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b1;
               end
            end
            default: begin
               r_rsp_rdata <= '0;
               r_rsp_err   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready     = ~w_full;
   assign bus.avm_address   = r_avm_addr;
   assign bus.avm_write     = r_avm_write;
   assign bus.avm_read      = r_avm_read;
   assign bus.avm_writedata = r_avm_wdata;
   assign bus.rsp_valid     = (r_state == RESP);
   assign bus.rsp_rdata     = r_rsp_rdata;
   assign bus.rsp_err       = r_rsp_err;
   assign bus.busy          = ~w_empty | (r_state != IDLE);

endmodule

// File: tb/tb_gpu_reg_master.sv
// Directed bench for gpu_reg_master: writes, stalled reads, bad
// addresses, read timeout, FIFO full/backpressure and mid-transfer reset.
module tb_gpu_reg_master;
   import gpu_reg_pkg::*;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   gpu_reg_master_if bus ();

   gpu_reg_master #(.FIFO_DEPTH(8), .RD_TIMEOUT(255)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic w, input logic [7:0] a,
                       input logic [31:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // tick until rsp_valid is seen; counts cycles and strobe cycles
   task automatic wait_rsp(input int maxc, output bit got,
                           output int cyc, output int strobes);
      got = 0;
      cyc = 0;
      strobes = 0;
      for (int i = 0; i < maxc; i++) begin
         if (bus.rsp_valid) begin
            got = 1;
            break;
         end
         if (bus.avm_write || bus.avm_read) strobes++;
         tick();
         cyc++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          got;
      int          cyc;
      int          strb;
      int          n_rsp;
      int          n_wr;
      logic        err_any;
      logic [7:0]  addrs [9];
      logic [31:0] datas [9];
      int          when  [9];

      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdata      = '0;
      bus.avm_readdatavalid = 1'b0;
      tick();
      tick();

      // reset state
      chk1("rst_ready", bus.cmd_ready, 1'b1);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_awr", bus.avm_write, 1'b0);
      chk1("rst_ard", bus.avm_read, 1'b0);
      chk1("rst_rsp", bus.rsp_valid, 1'b0);
      reset = 1'b0;
      tick();

      // 1: write 0x05 <- DEADBEEF, no stall
      push(1'b1, 8'h05, 32'hDEADBEEF);
      chk1("t1_busy", bus.busy, 1'b1);
      chk1("t1_nostrobe", bus.avm_write, 1'b0);
      tick();
      chk1("t1_awr", bus.avm_write, 1'b1);
      chk1("t1_ard", bus.avm_read, 1'b0);
      chk32("t1_addr", 32'(bus.avm_address), 32'h05);
      chk32("t1_wdata", bus.avm_writedata, 32'hDEADBEEF);
      chk1("t1_rsp_early", bus.rsp_valid, 1'b0);
      tick();
      chk1("t1_rsp", bus.rsp_valid, 1'b1);
      chk1("t1_err", bus.rsp_err, 1'b0);
      chk32("t1_rdata", bus.rsp_rdata, 32'h0);
      chk1("t1_awr_off", bus.avm_write, 1'b0);
      tick();
      chk1("t1_rsp_once", bus.rsp_valid, 1'b0);
      chk1("t1_idle", bus.busy, 1'b0);

      // 2: read 0x0A with 3 stall cycles, data 2 cycles after accept
      bus.avm_waitrequest = 1'b1;
      push(1'b0, 8'h0A, 32'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk1("t2_stall_rd", bus.avm_read, 1'b1);
         chk32("t2_stall_addr", 32'(bus.avm_address), 32'h0A);
         chk1("t2_stall_wr", bus.avm_write, 1'b0);
         tick();
      end
      bus.avm_waitrequest = 1'b0;
      chk1("t2_acc_rd", bus.avm_read, 1'b1);
      tick();
      chk1("t2_rd_drop", bus.avm_read, 1'b0);
      tick();
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata = 32'h1234;
      tick();
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata = 32'h0;
      chk1("t2_rsp", bus.rsp_valid, 1'b1);
      chk32("t2_rdata", bus.rsp_rdata, 32'h1234);
      chk1("t2_err", bus.rsp_err, 1'b0);
      tick();
      chk1("t2_rsp_once", bus.rsp_valid, 1'b0);

      // 3: bad addresses rejected locally, then a valid write
      push(1'b0, 8'h0B, 32'h0);
      wait_rsp(20, got, cyc, strb);
      chk1("t3a_got", got, 1'b1);
      chk1("t3a_err", bus.rsp_err, 1'b1);
      chk32("t3a_rdata", bus.rsp_rdata, 32'h0);
      chk32("t3a_strobes", 32'(strb), 32'd0);
      tick();
      push(1'b1, 8'hFF, 32'h77);
      wait_rsp(20, got, cyc, strb);
      chk1("t3b_got", got, 1'b1);
      chk1("t3b_err", bus.rsp_err, 1'b1);
      chk32("t3b_strobes", 32'(strb), 32'd0);
      tick();
      push(1'b1, 8'h03, 32'h55);
      wait_rsp(20, got, cyc, strb);
      chk1("t3c_got", got, 1'b1);
      chk1("t3c_err", bus.rsp_err, 1'b0);
      chk32("t3c_strobes", 32'(strb), 32'd1);
      tick();

      // 4: read 0x00 never answered -> timeout 255 cycles after accept
      push(1'b0, 8'h00, 32'h0);
      tick();
      chk1("t4_rd", bus.avm_read, 1'b1);
      tick();
      wait_rsp(400, got, cyc, strb);
      chk1("t4_got", got, 1'b1);
      chk32("t4_cycles", 32'(cyc), 32'd255);
      chk1("t4_err", bus.rsp_err, 1'b1);
      chk32("t4_rdata", bus.rsp_rdata, 32'h0);
      chk32("t4_strobes", 32'(strb), 32'd0);
      tick();
      chk1("t4_idle", bus.busy, 1'b0);
      chk1("t4_rsp_once", bus.rsp_valid, 1'b0);

      // 5: nine writes with waitrequest stuck high
      bus.avm_waitrequest = 1'b1;
      for (int k = 0; k < 9; k++) begin
         chk1("t5_ready", bus.cmd_ready, 1'b1);
         push(1'b1, 8'(k), 32'hA0 + 32'(k));
      end
      chk1("t5_full", bus.cmd_ready, 1'b0);
      chk1("t5_busy", bus.busy, 1'b1);
      tick();
      tick();
      chk1("t5_still_full", bus.cmd_ready, 1'b0);
      chk1("t5_held_wr", bus.avm_write, 1'b1);
      chk32("t5_held_addr", 32'(bus.avm_address), 32'h0);
      bus.avm_waitrequest = 1'b0;
      n_rsp = 0;
      n_wr = 0;
      err_any = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (bus.avm_write && n_wr < 9) begin
            addrs[n_wr] = bus.avm_address;
            datas[n_wr] = bus.avm_writedata;
            when[n_wr] = c;
            n_wr++;
         end
         if (bus.rsp_valid) begin
            n_rsp++;
            err_any = err_any | bus.rsp_err;
         end
         tick();
      end
      chk32("t5_nrsp", 32'(n_rsp), 32'd9);
      chk32("t5_nwr", 32'(n_wr), 32'd9);
      chk1("t5_err", err_any, 1'b0);
      for (int k = 0; k < 9; k++) begin
         if (k < n_wr) begin
            chk32("t5_order_addr", 32'(addrs[k]), 32'(k));
            chk32("t5_order_data", datas[k], 32'hA0 + 32'(k));
            if (k > 0)
               chk32("t5_gap", 32'(when[k] - when[k-1]), 32'd3);
         end
      end
      chk1("t5_idle", bus.busy, 1'b0);

      // 6: reset while a write stalls in ISSUE with 4 queued
      bus.avm_waitrequest = 1'b1;
      for (int k = 1; k <= 5; k++)
         push(1'b1, 8'(k), 32'(k));
      chk1("t6_pre_wr", bus.avm_write, 1'b1);
      chk1("t6_pre_busy", bus.busy, 1'b1);
      reset = 1'b1;
      #1;
      chk1("t6_wr_drop", bus.avm_write, 1'b0);
      chk1("t6_busy_drop", bus.busy, 1'b0);
      chk1("t6_ready", bus.cmd_ready, 1'b1);
      chk1("t6_rsp", bus.rsp_valid, 1'b0);
      tick();
      reset = 1'b0;
      bus.avm_waitrequest = 1'b0;
      n_rsp = 0;
      n_wr = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus.rsp_valid) n_rsp++;
         if (bus.avm_write || bus.avm_read) n_wr++;
      end
      chk32("t6_no_rsp", 32'(n_rsp), 32'd0);
      chk32("t6_no_strobe", 32'(n_wr), 32'd0);
      chk1("t6_idle", bus.busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
